// File: rtl/line_addr_compose_if.sv
// Request/beat-address bundle for line_addr_compose.
// master: the requester/consumer side; slave: the address composer.
interface line_addr_compose_if #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 6,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
);
  logic                req_valid;
  logic                req_ready;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                addr_valid;
  logic                addr_ready;
  logic [ADDR_W-1:0]   addr_out;
  logic                addr_last;
  logic                done;
  logic                busy;

  modport master (
    output req_valid, req_tag, req_index, req_offset, addr_ready,
    input  req_ready, addr_valid, addr_out, addr_last, done, busy
  );

  modport slave (
    input  req_valid, req_tag, req_index, req_offset, addr_ready,
    output req_ready, addr_valid, addr_out, addr_last, done, busy
  );
endinterface

// File: rtl/line_addr_compose.sv
// line_addr_compose: rebuilds full byte addresses {tag, index, offset} for
// one cache line and streams them as a per-beat burst with a last flag and a
// completion pulse.
// Optional feature macro: CRIT_WORD_FIRST_EN -- when defined the burst starts
// at the beat holding req_offset and wraps within the line; otherwise it
// always starts at offset 0.
//
// state | meaning
// IDLE  | ready for a line request, no address presented
// BURST | presenting beat addresses until the last one is accepted
module line_addr_compose #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 6,
  parameter int BEAT_W   = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input logic               clk,
  input logic               rst,
  line_addr_compose_if.slave bus
);

  localparam int BEATS = 2 ** (OFFSET_W - BEAT_W);
  localparam int CNT_W = (OFFSET_W > BEAT_W) ? (OFFSET_W - BEAT_W) : 1;
  localparam logic [OFFSET_W-1:0] BEAT_STEP = OFFSET_W'(2 ** BEAT_W);
  localparam logic [OFFSET_W-1:0] LOW_MASK  = OFFSET_W'(2 ** BEAT_W - 1);
  localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(BEATS - 1);

  if (OFFSET_W < BEAT_W || TAG_W < 1) begin : g_param_check
    $fatal(1, "line_addr_compose: need OFFSET_W >= BEAT_W and TAG_W >= 1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                last;

`ifndef CRIT_WORD_FIRST_EN
  // Offset is accepted on the port but has no effect on a linear burst.
  logic unused_req_offset;
  assign unused_req_offset = ^bus.req_offset;
`endif

  assign last = (cnt_q == LAST_CNT);

  // State and burst registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: latch the line on request, step the offset on each accepted beat.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    index_d = index_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          tag_d   = bus.req_tag;
          index_d = bus.req_index;
`ifdef CRIT_WORD_FIRST_EN
          off_d   = bus.req_offset & ~LOW_MASK;
`else
          off_d   = '0;
`endif
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (bus.addr_ready) begin
          // Offset wraps inside the line; it never carries into the index.
          off_d = off_q + BEAT_STEP;
          if (last) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.addr_valid = (state_q == BURST);
  assign bus.busy       = (state_q == BURST);
  assign bus.addr_last  = (state_q == BURST) && last;
  assign bus.addr_out   = (state_q == BURST) ? {tag_q, index_q, off_q} : '0;
  assign bus.done       = done_q;

endmodule

// File: doc/line_addr_compose.md
Name: line_addr_compose

Overview:
- Inverse of the cache address split: rebuilds full byte addresses from a line's tag and index.
- Issues them as a per-beat burst covering one cache line, for line fills and victim writebacks toward the memory interface.
- Accepts one line request at a time and streams beat addresses under a valid/ready handshake, with a last-beat flag and a completion pulse.

Parameters:
- ADDR_W, 32, full byte-address width
- INDEX_W, 14, set-index width
- OFFSET_W, 6, line-offset width (64-byte line)
- BEAT_W, 2, log2 of bytes per beat (4-byte beat)
- TAG_W, ADDR_W-INDEX_W-OFFSET_W, tag width (derived, 12 by default)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  line request present
- req_ready  out  1  block can accept a request
- req_tag  in  TAG_W  line tag
- req_index  in  INDEX_W  line set index
- req_offset  in  OFFSET_W  requested byte offset (critical word)
- addr_valid  out  1  addr_out holds a valid beat address
- addr_ready  in  1  consumer accepts the beat address
- addr_out  out  ADDR_W  {tag, index, beat_offset}
- addr_last  out  1  current beat is the final beat of the line
- done  out  1  one-cycle pulse after the last beat is accepted
- busy  out  1  burst in progress

Behaviour:
- BEATS = 2^(OFFSET_W-BEAT_W), 16 by default.
- Elaboration-time $fatal if OFFSET_W < BEAT_W or TAG_W < 1.
- Reset values: req_ready=1, addr_valid=0, addr_out=0, addr_last=0, done=0, busy=0, internal beat counter=0, state=IDLE.
- States: IDLE, BURST.
- IDLE:
  - req_ready=1, addr_valid=0.
  - On req_valid&&req_ready at a clock edge, latch tag, index and start offset. The start offset has its low BEAT_W bits forced to 0.
  - Go to BURST. addr_valid=1 from the next cycle (one-cycle request-to-first-address latency).
- BURST:
  - req_ready=0, busy=1.
  - addr_out = {tag, index, cur_off}, where cur_off is an OFFSET_W-bit value with its low BEAT_W bits always 0.
  - Beat accepted when addr_valid&&addr_ready at a clock edge. On acceptance, cur_off += 2^BEAT_W modulo 2^OFFSET_W (wraps within the line, never carries into index) and the beat counter increments.
  - addr_last=1 exactly when beat counter == BEATS-1.
  - Acceptance with addr_last=1: go to IDLE, addr_valid=0, done=1 for one cycle, counter cleared.
- Backpressure: while addr_valid&&!addr_ready, addr_out, addr_last and the counter hold stable. addr_valid is never withdrawn before acceptance.
- req_valid while busy: ignored; no latch, no state change. Requester must hold it until req_ready.
- Back-to-back requests: a new request is accepted no earlier than the cycle done is high (req_ready=1 in that IDLE cycle). This gives a one-cycle bubble between bursts.
- Reset asserted mid-burst: next cycle all outputs return to reset values. The remaining beats are discarded, with no done pulse.
- Tag and index are latched at acceptance. Changes on req_* during BURST do not affect addr_out.

Optional Feature:
- Macro: CRIT_WORD_FIRST_EN.
- Defined: the burst starts at the aligned req_offset and wraps modulo the line size (critical word first); BEATS beats total.
- Undefined: req_offset is ignored and the burst always starts at offset 0 and ascends linearly. The port remains present.

Test Plan:
- Linear burst: tag=0xABC, index=0x1234, offset=0, addr_ready=1 -> addr_out 0xABC48D00, 0xABC48D04 … 0xABC48D3C; addr_last only on 0xABC48D3C; 16 beats; done one cycle later; first addr_valid one cycle after request acceptance.
- Critical word first: same tag/index, offset=0x2B.
  - With CRIT_WORD_FIRST_EN: 0xABC48D28 … 0xABC48D3C, then 0xABC48D00 … 0xABC48D24 (last); no carry into index.
  - Without CRIT_WORD_FIRST_EN: starts at 0xABC48D00.
- Backpressure: drop addr_ready for 3 cycles while addr_out=0xABC48D14 -> addr_out/addr_last/addr_valid unchanged for those 3 cycles; sequence resumes at 0xABC48D18.
- Request during burst: pulse req_valid with tag=0x001 at beat 4 -> req_ready=0, stream unaffected, no second burst afterward unless re-requested.
- Reset mid-burst: assert rst at beat 7 -> next cycle addr_valid=0, busy=0, req_ready=1, no done. A new request of tag=0xFFF, index=0x3FFF starts at 0xFFFFFFC0 and ends at 0xFFFFFFFC.
- Back-to-back: hold req_valid high with a second request -> accepted in the done cycle; its first addr_valid appears the following cycle.
